dcache_data_wr_sched: RTL
=========================

Name: dcache_data_wr_sched

Overview:
- Write-port scheduler for the data cache's simple-dual-port data RAM (byte-enable write port B, write-first read port A).
- Collects 32-bit AXI refill beats into a one-line buffer and commits the line as a single full-width write.
- Queues store-hit writes in a small FIFO and sends them to the same port.
- Arbitrates refill vs. store at one RAM write per cycle. Sits between the miss unit/store pipeline and the data RAM.

Parameters:
- LINE, 128, number of cache lines (index width $clog2(LINE)).
- BLOCK, 8, 32-bit words per line.
- SQ_DEPTH, 2, store FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- refill_req_valid  in  1  start of a line refill
- refill_req_ready  out  1  scheduler can accept a refill (IDLE)
- refill_req_index  in  $clog2(LINE)  line being refilled
- beat_valid  in  1  refill data beat valid
- beat_ready  out  1  beat accepted (FILL state)
- beat_data  in  32  refill word, critical-word-first not supported (word 0 first)
- beat_last  in  1  last beat marker
- refill_done  out  1  one-cycle pulse: line written to RAM
- refill_err  out  1  sticky: beat_last mismatch seen; cleared only by rst
- st_valid  in  1  store write request
- st_ready  out  1  FIFO not full
- st_index  in  $clog2(LINE)  target line
- st_offset  in  $clog2(BLOCK)  target word
- st_strb  in  4  byte strobes
- st_data  in  32  store word
- ram_wen  out  4*BLOCK  byte write enables to RAM port B
- ram_windex  out  $clog2(LINE)  RAM write index
- ram_wdata  out  32*BLOCK  RAM write data
- idle  out  1  FSM IDLE and store FIFO empty (fence/flush drain)

Behaviour:
- Reset: FSM IDLE, beat counter 0, FIFO empty, refill_err 0. All outputs 0 except refill_req_ready=1, st_ready=1, idle=1. The line buffer is not reset.
- FSM IDLE -> FILL on refill_req_valid&&refill_req_ready; index latched.
- FILL: beat_ready=1. Each accepted beat writes buf[cnt] and increments cnt.
- On the 8th (BLOCK-th) accepted beat, go to WRITE and reset cnt to 0, regardless of beat_last.
- If beat_last disagrees with (cnt==BLOCK-1) on any accepted beat, set refill_err.
- WRITE (exactly one cycle): ram_wen all ones, ram_windex=latched index, ram_wdata=buffer, refill_done=1. Next state IDLE.
- Refill latency: RAM write occurs the cycle after the last beat handshake.
- Store FIFO: push on st_valid&&st_ready. st_ready=!full; there is no bypass when full, and push+pop in the same cycle is allowed when not full.
- Store issue: the head is sent to the RAM and popped in the same cycle when all of these hold:
  - FIFO not empty;
  - FSM not in WRITE;
  - not (FSM in FILL/WRITE and head index == latched refill index).
- Store write fields: ram_wen[4*off+:4]=strb, other bits 0. ram_wdata carries the store word replicated in every word slot. ram_windex=head index.
- Store latency: minimum one cycle after the accept (write at t+1).
- Ordering: a store to the refilling line waits until after the WRITE cycle, so it overwrites refill data. Head-of-line blocking is accepted.
- When nothing is issued, ram_wen=0. ram_windex/ram_wdata are don't-care.
- Priority: refill WRITE > store.
- A store with strb=0 is accepted and popped as a zero-wen no-op.
- rst mid-FILL: partial line discarded, no RAM write, refill_done not pulsed.
- Read/write collision on the same index is resolved inside the RAM (write-first) and needs no handling here.
- Exactly one RAM write per cycle; ram_wen never combines refill and store.

Decomposition:
- Shared package: FSM state enum {IDLE, FILL, WRITE}, a WORD_BYTES=4 constant, and a store-entry struct {index, offset, strb, data}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty) for the store queue.
- FSM, beat counter, line buffer and issue mux stay at the top level.

Test Plan:
- Refill index 0x05 with beats 0x0..0x7 back-to-back, last on beat 7 -> one cycle after beat 7: ram_wen=0xFFFFFFFF, ram_windex=5, word i = i, refill_done pulse, refill_err=0.
- Store idx 3, off 2, strb 0b0011, data 0xAABBCCDD while idle -> next cycle ram_wen=0x00000300, index 3, word 2 = 0xAABBCCDD.
- Refill idx 9 in FILL plus a store to idx 9 -> store held until after the WRITE cycle and written the cycle after refill_done. A store to idx 4 in the same window issues immediately.
- Push three stores with a blocked head (SQ_DEPTH=2) -> st_ready=0 after the second push. It returns to 1 the cycle after the head pops.
- beat_last asserted on beat 5 -> refill_err set and stays 1. The line is still written after the 8th beat.
- Assert rst after 4 beats -> no ram_wen, refill_req_ready=1, idle=1. A new refill then completes normally.

Source files
------------

// File: rtl/dcache_data_wr_sched_pkg.sv
// Shared types and constants for the data-RAM write-port scheduler.
package dcache_data_wr_sched_pkg;

    localparam int unsigned DEF_LINE   = 128;
    localparam int unsigned DEF_BLOCK  = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_BITS  = 8 * WORD_BYTES;
    localparam int unsigned IDX_W      = $clog2(DEF_LINE);
    localparam int unsigned OFF_W      = $clog2(DEF_BLOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } wr_state_e;

    // One queued store-hit write.
    typedef struct packed {
        logic [IDX_W-1:0]      index;
        logic [OFF_W-1:0]      offset;
        logic [WORD_BYTES-1:0] strb;
        logic [WORD_BITS-1:0]  data;
    } st_entry_t;

endpackage

// File: rtl/dcache_data_wr_sched_sync_fifo.sv
// Small synchronous FIFO used as the store-hit write queue. Head is visible on rdata.
module dcache_data_wr_sched_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/dcache_data_wr_sched.sv
// Data-RAM write-port scheduler: assembles refill beats into a line, queues store hits,
// and issues at most one write per cycle with the refill line write taking priority.
module dcache_data_wr_sched
    import dcache_data_wr_sched_pkg::*;
#(
    parameter int unsigned LINE     = DEF_LINE,
    parameter int unsigned BLOCK    = DEF_BLOCK,
    parameter int unsigned SQ_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          refill_req_valid,
    output logic                          refill_req_ready,
    input  logic [$clog2(LINE)-1:0]       refill_req_index,
    input  logic                          beat_valid,
    output logic                          beat_ready,
    input  logic [31:0]                   beat_data,
    input  logic                          beat_last,
    output logic                          refill_done,
    output logic                          refill_err,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [$clog2(LINE)-1:0]       st_index,
    input  logic [$clog2(BLOCK)-1:0]      st_offset,
    input  logic [3:0]                    st_strb,
    input  logic [31:0]                   st_data,
    output logic [4*BLOCK-1:0]            ram_wen,
    output logic [$clog2(LINE)-1:0]       ram_windex,
    output logic [32*BLOCK-1:0]           ram_wdata,
    output logic                          idle
);

    localparam int unsigned IW = $clog2(LINE);
    localparam int unsigned OW = $clog2(BLOCK);
    localparam logic [OW-1:0] LAST_BEAT = OW'(BLOCK - 1);

    // The store-entry struct is sized from the package defaults.
    if (LINE != DEF_LINE || BLOCK != DEF_BLOCK) begin : g_param_check
        $error("LINE/BLOCK must match the package store-entry widths");
    end

    wr_state_e     state;
    logic [OW-1:0] cnt;
    logic [IW-1:0] refill_idx;
    logic [31:0]   line_buf [BLOCK];

    logic          beat_fire;
    logic          fifo_full;
    logic          fifo_empty;
    logic          st_block;
    logic          st_issue;
    st_entry_t     st_in;
    st_entry_t     head;

    assign beat_fire = beat_valid && beat_ready;
    assign st_ready  = !fifo_full;
    assign idle      = (state == IDLE) && fifo_empty;

    assign st_in = '{index: st_index, offset: st_offset, strb: st_strb, data: st_data};

    // Refill FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            refill_idx       <= '0;
            refill_req_ready <= 1'b1;
            beat_ready       <= 1'b0;
            refill_done      <= 1'b0;
            refill_err       <= 1'b0;
        end else begin
            refill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (refill_req_valid && refill_req_ready) begin
                        state            <= FILL;
                        refill_idx       <= refill_req_index;
                        refill_req_ready <= 1'b0;
                        beat_ready       <= 1'b1;
                    end
                end
                FILL: begin
                    if (beat_fire) begin
                        // Length is fixed at BLOCK beats; beat_last only flags a protocol error.
                        if (beat_last != (cnt == LAST_BEAT)) refill_err <= 1'b1;
                        if (cnt == LAST_BEAT) begin
                            cnt         <= '0;
                            state       <= WRITE;
                            beat_ready  <= 1'b0;
                            refill_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state            <= IDLE;
                    refill_req_ready <= 1'b1;
                end
                default: begin
                    state            <= IDLE;
                    refill_req_ready <= 1'b1;
                    beat_ready       <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer capture; not reset since a partial line is never written out.
    always_ff @(posedge clk) begin
        if (beat_fire) line_buf[cnt] <= beat_data;
    end

    dcache_data_wr_sched_sync_fifo #(
        .WIDTH ($bits(st_entry_t)),
        .DEPTH (SQ_DEPTH)
    ) u_store_q (
        .clk   (clk),
        .rst   (rst),
        .push  (st_valid && st_ready),
        .wdata (st_in),
        .pop   (st_issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A store to the line being refilled must land after the line write.
    always_comb begin
        st_block = (state == WRITE) || ((state == FILL) && (head.index == refill_idx));
        st_issue = !fifo_empty && !st_block;
    end

    // Single write-port mux: refill line write wins over the store queue head.
    always_comb begin
        ram_wen    = '0;
        ram_windex = '0;
        ram_wdata  = '0;
        if (state == WRITE) begin
            ram_wen    = '1;
            ram_windex = refill_idx;
            for (int w = 0; w < int'(BLOCK); w++) begin
                ram_wdata[w*32 +: 32] = line_buf[w];
            end
        end else if (st_issue) begin
            ram_windex = head.index;
            for (int w = 0; w < int'(BLOCK); w++) begin
                ram_wdata[w*32 +: 32] = head.data;
                if (head.offset == OW'(w)) ram_wen[w*WORD_BYTES +: WORD_BYTES] = head.strb;
            end
        end
    end

endmodule
